// File: rtl/exp_strip_packer.sv
// Drops the constant exponent of each 32-bit float word and packs the remaining
// 24-bit {sign, mantissa} symbols densely into 32-bit output words (4 in -> 3 out).
module exp_strip_packer #(
   parameter logic [7:0]  EXP_CONST = 8'h7F,
   parameter int unsigned ERR_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      s_data,
   input  logic             s_valid,
   input  logic             s_last,
   output logic             s_ready,
   output logic [31:0]      m_data,
   output logic             m_valid,
   output logic             m_last,
   output logic [2:0]       m_bytes,
   input  logic             m_ready,
   output logic             exp_err,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [0:0] {StRun, StFlush} state_t;

   state_t           state_q, state_d;
   logic [55:0]      acc_q, acc_d;
   logic [5:0]       r_q, r_d;
   logic [31:0]      m_data_q, m_data_d;
   logic             m_valid_q, m_valid_d;
   logic             m_last_q, m_last_d;
   logic [2:0]       m_bytes_q, m_bytes_d;
   logic             exp_err_q, exp_err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic             out_free;
   logic             accept;
   logic [23:0]      sym;
   logic [55:0]      merged;
   logic [5:0]       t;

   assign out_free = !m_valid_q || m_ready;
   assign s_ready  = (state_q == StRun) && out_free;
   assign accept   = s_valid && s_ready;
   assign sym      = {s_data[31], s_data[22:0]};
   // Bits of acc_q above r_q are always zero, so OR-ing the shifted symbol is exact.
   assign merged   = acc_q | ({32'd0, sym} << r_q);
   assign t        = r_q + 6'd24;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      r_d       = r_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_bytes_d = m_bytes_q;
      exp_err_d = 1'b0;
      err_cnt_d = err_cnt_q;

      if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end

      unique case (state_q)
         StRun: begin
            if (accept) begin
               if (s_data[30:23] != EXP_CONST) begin
                  exp_err_d = 1'b1;
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + ERR_W'(1);
                  end
               end
               if (t < 6'd32) begin
                  acc_d = merged;
                  r_d   = t;
                  if (s_last) begin
                     m_data_d  = merged[31:0];
                     m_valid_d = 1'b1;
                     m_last_d  = 1'b1;
                     m_bytes_d = t[5:3];
                     acc_d     = '0;
                     r_d       = '0;
                  end
               end else begin
                  m_data_d  = merged[31:0];
                  m_valid_d = 1'b1;
                  m_last_d  = s_last && (t == 6'd32);
                  m_bytes_d = 3'd4;
                  acc_d     = merged >> 32;
                  r_d       = t - 6'd32;
                  if (s_last && (t != 6'd32)) begin
                     state_d = StFlush;
                  end
               end
            end
         end
         StFlush: begin
            if (out_free) begin
               m_data_d  = acc_q[31:0];
               m_valid_d = 1'b1;
               m_last_d  = 1'b1;
               m_bytes_d = r_q[5:3];
               acc_d     = '0;
               r_d       = '0;
               state_d   = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StRun;
         acc_q     <= '0;
         r_q       <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_bytes_q <= '0;
         exp_err_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         r_q       <= r_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         m_bytes_q <= m_bytes_d;
         exp_err_q <= exp_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign m_data  = m_data_q;
   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign m_bytes = m_bytes_q;
   assign exp_err = exp_err_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_exp_strip_packer.sv
// Bench for exp_strip_packer: directed vectors plus randomized blocks checked
// against a byte-stream reference model.
module tb_exp_strip_packer;

   localparam int TB_ERR_W = 6;
   localparam int MAXC     = (1 << TB_ERR_W) - 1;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [31:0]         s_data;
   logic                s_valid;
   logic                s_last;
   logic                s_ready;
   logic [31:0]         m_data;
   logic                m_valid;
   logic                m_last;
   logic [2:0]          m_bytes;
   logic                m_ready;
   logic                exp_err;
   logic [TB_ERR_W-1:0] err_cnt;

   exp_strip_packer #(
      .EXP_CONST (8'h7F),
      .ERR_W     (TB_ERR_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_last  (s_last),
      .s_ready (s_ready),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_last  (m_last),
      .m_bytes (m_bytes),
      .m_ready (m_ready),
      .exp_err (exp_err),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   int          err_pulses = 0;
   int          exp_err_total = 0;
   int          ready_mode = 1;
   logic [35:0] got[$];
   logic [35:0] expq[$];

   // m_ready: 0 = held low, 1 = held high, otherwise random
   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0)      m_ready = 1'b0;
         else if (ready_mode == 1) m_ready = 1'b1;
         else                      m_ready = ($urandom_range(0, 3) != 0);
      end
   end

   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) got.push_back({m_last, m_bytes, m_data});
      if (rst_n && exp_err) err_pulses++;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Reference: each word contributes 3 little-endian symbol bytes; output words are
   // consecutive 4-byte groups, the final group possibly short and flagged last.
   function automatic int model_block(input logic [31:0] w[$]);
      byte unsigned b[$];
      int           nbad = 0;
      int           nb;
      logic [23:0]  sym;
      logic [31:0]  data;
      foreach (w[i]) begin
         sym = {w[i][31], w[i][22:0]};
         b.push_back(sym[7:0]);
         b.push_back(sym[15:8]);
         b.push_back(sym[23:16]);
         if (w[i][30:23] != 8'h7F) nbad++;
      end
      for (int j = 0; j < b.size(); j += 4) begin
         nb = b.size() - j;
         if (nb > 4) nb = 4;
         data = '0;
         for (int k = 0; k < nb; k++) data[8*k +: 8] = b[j+k];
         expq.push_back({(j + 4 >= b.size()) ? 1'b1 : 1'b0, 3'(nb), data});
      end
      exp_err_total += nbad;
      return nbad;
   endfunction

   task automatic push(input logic [31:0] d, input logic last);
      int n = 0;
      s_data  = d;
      s_valid = 1'b1;
      s_last  = last;
      @(negedge clk);
      while (!s_ready && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (!s_ready) begin
         checks++;
         failures++;
         $display("FAIL push_timeout data=%08h s_ready stuck at 0, required 1", d);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
   endtask

   task automatic send_block(input logic [31:0] w[$], input int gap_max);
      foreach (w[i]) begin
         repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
         end
         push(w[i], i == w.size() - 1);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (got.size() < expq.size() && n < 3000) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      got.delete();
      expq.delete();
      exp_err_total = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({m_valid, m_last, m_bytes, m_data} !== 37'd0) begin
         failures++;
         $display("FAIL reset_out got v=%0b l=%0b b=%0d d=%08h required all 0",
                  m_valid, m_last, m_bytes, m_data);
      end
      checks++;
      if (exp_err !== 1'b0 || err_cnt !== '0) begin
         failures++;
         $display("FAIL reset_err got exp_err=%0b err_cnt=%0d required 0/0", exp_err, err_cnt);
      end
      checks++;
      if (s_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got %0b required 1", s_ready);
      end
   endtask

   task automatic test_vectors();
      logic [31:0] w[$];
      logic [35:0] lit[$];
      int          nbad;
      ready_mode = 1;
      // vector 1
      w = '{32'h3F800001, 32'h3F800002, 32'hBF800003, 32'h3F800004};
      nbad = model_block(w);
      lit = '{{1'b0, 3'd4, 32'h02000001}, {1'b0, 3'd4, 32'h00030000}, {1'b1, 3'd4, 32'h00000480}};
      send_block(w, 0);
      drain();
      checks++;
      if (got.size() != 3 || expq.size() != 3) begin
         failures++;
         $display("FAIL vec1_count got %0d words required 3", got.size());
      end
      for (int i = 0; i < got.size() && i < 3; i++) begin
         checks++;
         if (got[i] !== lit[i] || got[i] !== expq[i]) begin
            failures++;
            $display("FAIL vec1_word%0d got %09h required %09h", i, got[i], lit[i]);
         end
      end
      got.delete();
      expq.delete();
      // vector 2
      w = '{32'h3F812345};
      nbad = model_block(w);
      send_block(w, 0);
      drain();
      checks++;
      if (got.size() != 1 || got[0] !== {1'b1, 3'd3, 32'h00012345} || got[0] !== expq[0]) begin
         failures++;
         $display("FAIL vec2_word got n=%0d first=%09h required 1 word %09h", got.size(),
                  (got.size() > 0) ? got[0] : 36'd0, {1'b1, 3'd3, 32'h00012345});
      end
      got.delete();
      expq.delete();
      // vector 3: second accept completes a word and leaves 16 bits for FLUSH
      w = '{32'h3F800001, 32'h3FABCDEF};
      nbad = model_block(w);
      push(w[0], 1'b0);
      push(w[1], 1'b1);
      checks++;
      if (s_ready !== 1'b0) begin
         failures++;
         $display("FAIL vec3_flush_ready got %0b required 0", s_ready);
      end
      drain();
      lit = '{{1'b0, 3'd4, 32'hEF000001}, {1'b1, 3'd2, 32'h00002BCD}};
      checks++;
      if (got.size() != 2) begin
         failures++;
         $display("FAIL vec3_count got %0d words required 2", got.size());
      end
      for (int i = 0; i < got.size() && i < 2; i++) begin
         checks++;
         if (got[i] !== lit[i] || got[i] !== expq[i]) begin
            failures++;
            $display("FAIL vec3_word%0d got %09h required %09h", i, got[i], lit[i]);
         end
      end
      got.delete();
      expq.delete();
   endtask

   task automatic test_exp_err();
      logic [31:0] w[$];
      int          p0;
      int          nbad;
      ready_mode = 1;
      p0 = err_pulses;
      w = '{32'h40000000};
      nbad = model_block(w);
      send_block(w, 0);
      drain();
      checks++;
      if (got.size() != 1 || got[0] !== {1'b1, 3'd3, 32'h00000000}) begin
         failures++;
         $display("FAIL experr_word got n=%0d first=%09h required %09h", got.size(),
                  (got.size() > 0) ? got[0] : 36'd0, {1'b1, 3'd3, 32'h00000000});
      end
      checks++;
      if (err_pulses - p0 != nbad) begin
         failures++;
         $display("FAIL experr_pulse got %0d pulses required %0d", err_pulses - p0, nbad);
      end
      checks++;
      if (err_cnt !== TB_ERR_W'(exp_err_total)) begin
         failures++;
         $display("FAIL experr_cnt got %0d required %0d", err_cnt, exp_err_total);
      end
      got.delete();
      expq.delete();
   endtask

   task automatic test_backpressure();
      logic [31:0] w[$];
      logic [35:0] held;
      int          nbad;
      int          n;
      w = '{32'h3F800001, 32'h3F800002, 32'hBF800003, 32'h3F800004};
      nbad = model_block(w);
      ready_mode = 0;
      @(posedge clk);
      #2;
      fork
         send_block(w, 0);
         begin
            n = 0;
            @(negedge clk);
            while (!m_valid && n < 50) begin
               n++;
               @(negedge clk);
            end
            held = {m_last, m_bytes, m_data};
            repeat (5) begin
               @(negedge clk);
               checks++;
               if ({m_last, m_bytes, m_data} !== held || m_valid !== 1'b1) begin
                  failures++;
                  $display("FAIL bp_hold got v=%0b %09h required v=1 %09h", m_valid,
                           {m_last, m_bytes, m_data}, held);
               end
               checks++;
               if (s_ready !== 1'b0) begin
                  failures++;
                  $display("FAIL bp_ready got %0b required 0", s_ready);
               end
            end
            ready_mode = 1;
         end
      join
      drain();
      checks++;
      if (got.size() != expq.size()) begin
         failures++;
         $display("FAIL bp_count got %0d required %0d", got.size(), expq.size());
      end
      for (int i = 0; i < got.size() && i < expq.size(); i++) begin
         checks++;
         if (got[i] !== expq[i]) begin
            failures++;
            $display("FAIL bp_word%0d got %09h required %09h", i, got[i], expq[i]);
         end
      end
      got.delete();
      expq.delete();
   endtask

   task automatic test_reset_midblock();
      logic [31:0] w[$];
      int          nbad;
      ready_mode = 1;
      push(32'h3F800001, 1'b0);
      push(32'h3F800002, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({m_valid, m_last, m_bytes, m_data} !== 37'd0 || exp_err !== 1'b0 || err_cnt !== '0) begin
         failures++;
         $display("FAIL midrst_out got v=%0b l=%0b b=%0d d=%08h e=%0b c=%0d required all 0",
                  m_valid, m_last, m_bytes, m_data, exp_err, err_cnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      got.delete();
      expq.delete();
      exp_err_total = 0;
      w = '{32'h3F800001, 32'h3F800002, 32'hBF800003, 32'h3F800004};
      nbad = model_block(w);
      send_block(w, 0);
      drain();
      checks++;
      if (got.size() != expq.size()) begin
         failures++;
         $display("FAIL midrst_count got %0d required %0d", got.size(), expq.size());
      end
      for (int i = 0; i < got.size() && i < expq.size(); i++) begin
         checks++;
         if (got[i] !== expq[i]) begin
            failures++;
            $display("FAIL midrst_word%0d got %09h required %09h", i, got[i], expq[i]);
         end
      end
      got.delete();
      expq.delete();
   endtask

   task automatic test_random();
      logic [31:0] w[$];
      logic [7:0]  e;
      int          nbad;
      int          p0;
      int          bad_sum = 0;
      do_reset();
      ready_mode = 2;
      p0 = err_pulses;
      for (int blk = 0; blk < 30; blk++) begin
         w.delete();
         for (int i = 0; i < $urandom_range(1, 9); i++) begin
            e = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h7F;
            w.push_back({1'($urandom), e, 23'($urandom)});
         end
         nbad = model_block(w);
         bad_sum += nbad;
         send_block(w, 2);
      end
      drain();
      ready_mode = 1;
      checks++;
      if (got.size() != expq.size()) begin
         failures++;
         $display("FAIL rand_count got %0d required %0d", got.size(), expq.size());
      end
      for (int i = 0; i < got.size() && i < expq.size(); i++) begin
         checks++;
         if (got[i] !== expq[i]) begin
            failures++;
            $display("FAIL rand_word%0d got %09h required %09h", i, got[i], expq[i]);
         end
      end
      checks++;
      if (err_pulses - p0 != bad_sum) begin
         failures++;
         $display("FAIL rand_pulses got %0d required %0d", err_pulses - p0, bad_sum);
      end
      checks++;
      if (err_cnt !== TB_ERR_W'((exp_err_total > MAXC) ? MAXC : exp_err_total)) begin
         failures++;
         $display("FAIL rand_errcnt got %0d required %0d", err_cnt,
                  (exp_err_total > MAXC) ? MAXC : exp_err_total);
      end
      got.delete();
      expq.delete();
   endtask

   task automatic test_saturation();
      logic [31:0] w[$];
      int          nbad;
      ready_mode = 1;
      for (int i = 0; i < MAXC + 8; i++) w.push_back({1'($urandom), 8'h00, 23'($urandom)});
      nbad = model_block(w);
      send_block(w, 0);
      drain();
      checks++;
      if (err_cnt !== TB_ERR_W'(MAXC)) begin
         failures++;
         $display("FAIL sat_errcnt got %0d required %0d", err_cnt, MAXC);
      end
      checks++;
      if (got.size() != expq.size()) begin
         failures++;
         $display("FAIL sat_count got %0d required %0d", got.size(), expq.size());
      end
      for (int i = 0; i < got.size() && i < expq.size(); i++) begin
         checks++;
         if (got[i] !== expq[i]) begin
            failures++;
            $display("FAIL sat_word%0d got %09h required %09h", i, got[i], expq[i]);
         end
      end
      // one more bad word must leave the saturated count unchanged
      w = '{32'h40000001};
      nbad = model_block(w);
      send_block(w, 0);
      drain();
      checks++;
      if (err_cnt !== TB_ERR_W'(MAXC)) begin
         failures++;
         $display("FAIL sat_hold got %0d required %0d", err_cnt, MAXC);
      end
      got.delete();
      expq.delete();
   endtask

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      test_reset();
      test_vectors();
      test_exp_err();
      test_backpressure();
      test_reset_midblock();
      test_random();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
